// File: rtl/regbank.sv
// rtl/regbank.sv - 32x32 register file, two async read ports, one sync write port, reg 0 reads zero
module regbank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we3,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd3,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_en;

   // Entry 0 is never written; the read muxes also force it to zero so it is clean before reset.
   assign w_wr_en = we3 && (a3 != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[a3] <= wd3;
      end
   end

   assign rd1 = (a1 == '0) ? '0 : r_mem[a1];
   assign rd2 = (a2 == '0) ? '0 : r_mem[a2];

endmodule

// File: tb/tb_regbank.sv
// tb/tb_regbank.sv - scoreboard bench for the regbank register file
module tb_regbank;

   logic        clk;
   logic        rst;
   logic        we3;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [31:0] rd1;
   logic [31:0] rd2;

   int total;
   int bad;

   logic [31:0] mdl [32];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];

   regbank #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .we3 (we3),
      .a1  (a1),
      .a2  (a2),
      .a3  (a3),
      .wd3 (wd3),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Drive both read addresses, queue the expected data, then compare once the outputs settle.
   task automatic rd_chk(input string tag, input logic [4:0] x, input logic [4:0] y,
                         input logic [31:0] e1, input logic [31:0] e2);
      logic [31:0] x1;
      logic [31:0] x2;
      a1 = x;
      a2 = y;
      q1.push_back(e1);
      q2.push_back(e2);
      #1;
      x1 = q1.pop_front();
      x2 = q2.pop_front();
      check_val({tag, "_rd1"}, rd1, x1);
      check_val({tag, "_rd2"}, rd2, x2);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
      @(negedge clk);
      we3 = en;
      a3  = a;
      wd3 = d;
      @(posedge clk);
      if (en && a != 5'd0 && rst) mdl[a] = d;
      #1;
      we3 = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      rst = 1'b0;
      we3 = 1'b0;
      a1  = 5'd0;
      a2  = 5'd0;
      a3  = 5'd0;
      wd3 = 32'h0;

      #12;
      rd_chk("in_reset", 5'd4, 5'd17, 32'h0, 32'h0);
      rst = 1'b1;
      #1;
      rd_chk("post_reset", 5'd31, 5'd1, 32'h0, 32'h0);

      // Basic write/read
      wr(5'd5, 32'hDEADBEEF, 1'b1);
      rd_chk("basic", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

      // Register 0 protection
      wr(5'd0, 32'hFFFFFFFF, 1'b1);
      rd_chk("reg0", 5'd0, 5'd0, 32'h0, 32'h0);

      // Write enable gating
      wr(5'd7, 32'h12345678, 1'b1);
      wr(5'd7, 32'hAAAAAAAA, 1'b0);
      rd_chk("we_gate", 5'd7, 5'd5, 32'h12345678, 32'hDEADBEEF);

      // Reset mid-cycle with a write presented; it must be discarded
      wr(5'd3, 32'h33333333, 1'b1);
      @(negedge clk);
      we3 = 1'b1;
      a3  = 5'd3;
      wd3 = 32'h55555555;
      #2;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      for (int i = 0; i < 32; i++) rd_chk("rst_async", 5'(i), 5'(31 - i), 32'h0, 32'h0);
      we3 = 1'b0;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) rd_chk("rst_release", 5'(i), 5'(31 - i), 32'h0, 32'h0);

      // Dual-port sweep
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101, 1'b1);
      for (int i = 0; i < 32; i++)
         rd_chk("sweep", 5'(i), 5'(31 - i), 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101);
      for (int i = 0; i < 8; i++) begin
         logic [4:0] x;
         logic [4:0] y;
         x = 5'($urandom_range(0, 31));
         y = 5'($urandom_range(0, 31));
         rd_chk("rand", x, y, mdl[x], mdl[y]);
      end

      // Read during write: no bypass
      @(negedge clk);
      we3 = 1'b1;
      a3  = 5'd9;
      wd3 = 32'h0BADF00D;
      rd_chk("rdw_before", 5'd9, 5'd9, 32'h09090909, 32'h09090909);
      @(posedge clk);
      #1;
      we3 = 1'b0;
      rd_chk("rdw_after", 5'd9, 5'd10, 32'h0BADF00D, 32'h0A0A0A0A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
